// File: rtl/range_check_sequencer.sv
// Sequencer for the 12-element vector range checker: gathers a frame, starts the checker and reports the result.
// Optional checker watchdog is enabled by defining RANGE_SEQ_TIMEOUT_EN.
module range_check_sequencer #(
    parameter int VEC_LEN = 12,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
    input  logic                      clock,
    input  logic                      resetN,
    input  logic                      cfgWe,
    input  logic [DATA_W-1:0]         cfgLower,
    input  logic [DATA_W-1:0]         cfgUpper,
    output logic                      cfgErr,
    input  logic                      inValid,
    output logic                      inReady,
    input  logic [DATA_W-1:0]         inData,
    output logic                      chkStart,
    output logic [VEC_LEN*DATA_W-1:0] chkVector,
    output logic [DATA_W-1:0]         chkLower,
    output logic [DATA_W-1:0]         chkUpper,
    input  logic                      chkDone,
    input  logic [VEC_LEN-1:0]        chkErrMask,
    output logic                      resValid,
    input  logic                      resReady,
    output logic [VEC_LEN-1:0]        resErrMask,
    output logic [CNT_W-1:0]          resErrCount,
    output logic [CNT_W-1:0]          resFirstErr,
    output logic                      resTimeout
);

    typedef enum logic [1:0] {LOAD, START, WAIT, REPORT} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [VEC_LEN*DATA_W-1:0] vec_q, vec_d;
    logic [DATA_W-1:0]         lower_q, lower_d;
    logic [DATA_W-1:0]         upper_q, upper_d;
    logic                      cfgErr_q, cfgErr_d;
    logic [VEC_LEN-1:0]        mask_q, mask_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [CNT_W-1:0]          first_q, first_d;
    logic [CNT_W-1:0]          errCount_c, errFirst_c;
    logic                      accept;
    logic                      waitExpired;

`ifdef RANGE_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] waitCnt_q;
    logic            timeout_q;

    assign waitExpired = (waitCnt_q == TO_W'(TIMEOUT - 1));
    assign resTimeout  = timeout_q;

    // Counter is held at zero outside WAIT, so every WAIT visit starts fresh
    always_ff @(posedge clock) begin
        if (!resetN) begin
            waitCnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            waitCnt_q <= (state_q == WAIT) ? waitCnt_q + TO_W'(1) : '0;
            if (state_q == WAIT && state_d == REPORT) begin
                timeout_q <= !chkDone;
            end
        end
    end
`else
    // Without the watchdog WAIT never expires
    assign waitExpired = (TIMEOUT < 0);
    assign resTimeout  = 1'b0;
`endif

    assign inReady    = (state_q == LOAD) && resetN;
    assign accept     = inValid && inReady;
    assign chkStart   = (state_q == START);
    assign chkVector  = vec_q;
    assign chkLower   = lower_q;
    assign chkUpper   = upper_q;
    assign cfgErr     = cfgErr_q;
    assign resValid   = (state_q == REPORT);
    assign resErrMask = mask_q;
    assign resErrCount = count_q;
    assign resFirstErr = first_q;

    always_comb begin
        errCount_c = '0;
        errFirst_c = CNT_W'(VEC_LEN);
        for (int i = VEC_LEN - 1; i >= 0; i--) begin
            if (chkErrMask[i]) begin
                errCount_c = errCount_c + CNT_W'(1);
                errFirst_c = CNT_W'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        vec_d    = vec_q;
        lower_d  = lower_q;
        upper_d  = upper_q;
        cfgErr_d = 1'b0;
        mask_d   = mask_q;
        count_d  = count_q;
        first_d  = first_q;

        // Bounds may only move between frames, before the first element lands
        if (cfgWe) begin
            if (state_q == LOAD && cnt_q == '0 && cfgLower <= cfgUpper) begin
                lower_d = cfgLower;
                upper_d = cfgUpper;
            end else begin
                cfgErr_d = 1'b1;
            end
        end

        case (state_q)
            LOAD: begin
                if (accept) begin
                    for (int i = 0; i < VEC_LEN; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            vec_d[i*DATA_W +: DATA_W] = inData;
                        end
                    end
                    if (cnt_q == CNT_W'(VEC_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = START;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (chkDone) begin
                    mask_d  = chkErrMask;
                    count_d = errCount_c;
                    first_d = errFirst_c;
                    state_d = REPORT;
                end else if (waitExpired) begin
                    mask_d  = '1;
                    count_d = CNT_W'(VEC_LEN);
                    first_d = '0;
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (resReady) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q  <= LOAD;
            cnt_q    <= '0;
            vec_q    <= '0;
            lower_q  <= '0;
            upper_q  <= '1;
            cfgErr_q <= 1'b0;
            mask_q   <= '0;
            count_q  <= '0;
            first_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vec_q    <= vec_d;
            lower_q  <= lower_d;
            upper_q  <= upper_d;
            cfgErr_q <= cfgErr_d;
            mask_q   <= mask_d;
            count_q  <= count_d;
            first_q  <= first_d;
        end
    end

endmodule

// File: tb/tb_range_check_sequencer.sv
// Scoreboard bench for range_check_sequencer: randomized frames against a behavioural range-check model.
module tb_range_check_sequencer;

    localparam int VEC_LEN = 12;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 4;

    logic                      clock = 1'b0;
    logic                      resetN;
    logic                      cfgWe;
    logic [DATA_W-1:0]         cfgLower, cfgUpper;
    logic                      cfgErr;
    logic                      inValid, inReady;
    logic [DATA_W-1:0]         inData;
    logic                      chkStart;
    logic [VEC_LEN*DATA_W-1:0] chkVector;
    logic [DATA_W-1:0]         chkLower, chkUpper;
    logic                      chkDone;
    logic [VEC_LEN-1:0]        chkErrMask;
    logic                      resValid, resReady;
    logic [VEC_LEN-1:0]        resErrMask;
    logic [CNT_W-1:0]          resErrCount, resFirstErr;
    logic                      resTimeout;

    typedef struct {
        logic [VEC_LEN-1:0] mask;
        logic [CNT_W-1:0]   count;
        logic [CNT_W-1:0]   first;
        logic               tout;
    } expect_t;

    expect_t     expQ[$];
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  refLower, refUpper;
    logic [7:0]  frameData [VEC_LEN];
    int          readyMode = 0;
    int          checkerMode = 0;
    int          strayReq = 0;

    always #5 clock = ~clock;

    range_check_sequencer dut (
        .clock(clock), .resetN(resetN),
        .cfgWe(cfgWe), .cfgLower(cfgLower), .cfgUpper(cfgUpper), .cfgErr(cfgErr),
        .inValid(inValid), .inReady(inReady), .inData(inData),
        .chkStart(chkStart), .chkVector(chkVector), .chkLower(chkLower), .chkUpper(chkUpper),
        .chkDone(chkDone), .chkErrMask(chkErrMask),
        .resValid(resValid), .resReady(resReady), .resErrMask(resErrMask),
        .resErrCount(resErrCount), .resFirstErr(resFirstErr), .resTimeout(resTimeout)
    );

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reference: an element is in error when it lies outside [lo, up]
    function automatic expect_t modelFrame(input logic [7:0] lo, input logic [7:0] up);
        expect_t e;
        int idx;
        e.mask = '0;
        for (int i = 0; i < VEC_LEN; i++) begin
            e.mask[i] = (frameData[i] < lo) || (frameData[i] > up);
        end
        e.count = CNT_W'($countones(e.mask));
        idx = 0;
        while (idx < VEC_LEN && !e.mask[idx]) idx++;
        e.first = CNT_W'(idx);
        e.tout  = 1'b0;
        return e;
    endfunction

    function automatic logic [VEC_LEN*DATA_W-1:0] packFrame();
        logic [VEC_LEN*DATA_W-1:0] v;
        for (int i = 0; i < VEC_LEN; i++) v[i*DATA_W +: DATA_W] = frameData[i];
        return v;
    endfunction

    // External checker emulation: evaluates the presented vector and answers after a delay
    initial begin : checkerModel
        int                 countdown;
        int                 strayAck;
        logic [VEC_LEN-1:0] pending;
        countdown  = 0;
        strayAck   = 0;
        pending    = '0;
        chkDone    = 1'b0;
        chkErrMask = '0;
        forever begin
            @(negedge clock);
            chkDone    = 1'b0;
            chkErrMask = VEC_LEN'($urandom);
            if (strayReq != strayAck) begin
                strayAck = strayReq;
                chkDone  = 1'b1;
            end else if (countdown == 1) begin
                chkDone    = 1'b1;
                chkErrMask = pending;
                countdown  = 0;
            end else if (countdown > 1) begin
                countdown--;
            end
            if (chkStart && resetN && checkerMode != 2) begin
                for (int i = 0; i < VEC_LEN; i++) begin
                    pending[i] = (chkVector[i*DATA_W +: DATA_W] < chkLower) ||
                                 (chkVector[i*DATA_W +: DATA_W] > chkUpper);
                end
                countdown = (checkerMode == 1) ? 4 : 1 + int'($urandom_range(0, 3));
            end
            if (!resetN) countdown = 0;
        end
    end

    initial begin : readyDriver
        resReady = 1'b1;
        forever begin
            @(posedge clock);
            #2;
            case (readyMode)
                0:       resReady = 1'b1;
                1:       resReady = 1'($urandom_range(0, 1));
                default: resReady = 1'b0;
            endcase
        end
    end

    // Monitor: every completed result handshake is compared with the oldest expectation
    always @(negedge clock) begin
        expect_t e;
        if (resetN && resValid && resReady) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpectedResult: got mask %0h expected no result", resErrMask);
            end else begin
                e = expQ.pop_front();
                checkOutput("resErrMask", 128'(resErrMask), 128'(e.mask));
                checkOutput("resErrCount", 128'(resErrCount), 128'(e.count));
                checkOutput("resFirstErr", 128'(resFirstErr), 128'(e.first));
                checkOutput("resTimeout", 128'(resTimeout), 128'(e.tout));
            end
        end
    end

    task automatic applyStimulus(input bit gaps, input int fromIdx, input int toIdx);
        int sent;
        int guard;
        bit acc;
        sent  = fromIdx;
        guard = 0;
        while (sent < toIdx && guard < 1000) begin
            inValid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            inData  = frameData[sent];
            @(negedge clock);
            acc = inValid && inReady;
            @(posedge clock);
            #1;
            if (acc) sent++;
            guard++;
        end
        inValid = 1'b0;
        inData  = 8'($urandom);
        if (sent < toIdx) begin
            checks++;
            failures++;
            $display("[TB] FAIL loadTimeout: got %0d elements expected %0d", sent, toIdx);
        end
    endtask

    // Sends a whole frame and checks the start pulse; returns one cycle into WAIT
    task automatic sendFrame(input bit gaps, input bit expectTimeout);
        expect_t e;
        applyStimulus(gaps, 0, VEC_LEN);
        e = modelFrame(refLower, refUpper);
        if (expectTimeout) begin
            e.mask  = '1;
            e.count = CNT_W'(VEC_LEN);
            e.first = '0;
            e.tout  = 1'b1;
        end
        expQ.push_back(e);
        @(negedge clock);
        checkOutput("startPulse", 128'(chkStart), 128'(1));
        checkOutput("vectorAtStart", 128'(chkVector), 128'(packFrame()));
        checkOutput("inReadyInStart", 128'(inReady), 128'(0));
        @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("startOneCycle", 128'(chkStart), 128'(0));
        @(posedge clock);
        #1;
    endtask

    task automatic writeBounds(input logic [7:0] lo, input logic [7:0] up, input bit idle);
        bit accept;
        accept   = idle && (lo <= up);
        cfgWe    = 1'b1;
        cfgLower = lo;
        cfgUpper = up;
        @(posedge clock);
        #1;
        cfgWe    = 1'b0;
        cfgLower = 8'($urandom);
        cfgUpper = 8'($urandom);
        if (accept) begin
            refLower = lo;
            refUpper = up;
        end
        @(negedge clock);
        checkOutput("cfgErr", 128'(cfgErr), 128'(!accept));
        checkOutput("chkLower", 128'(chkLower), 128'(refLower));
        checkOutput("chkUpper", 128'(chkUpper), 128'(refUpper));
        @(posedge clock);
        #1;
        @(negedge clock);
        checkOutput("cfgErrPulseEnd", 128'(cfgErr), 128'(0));
        @(posedge clock);
        #1;
    endtask

    task automatic waitResults();
        int guard;
        guard = 0;
        while (expQ.size() != 0 && guard < 300) begin
            @(posedge clock);
            #1;
            guard++;
        end
        if (expQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL resultTimeout: got %0d pending expected 0", expQ.size());
            expQ.delete();
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL globalTimeout: got no completion expected $finish");
        $fatal(1, "[TB] simulation stalled");
    end

    initial begin : mainSeq
        logic [VEC_LEN-1:0] snapMask;
        logic [CNT_W-1:0]   snapCount, snapFirst;
        logic [7:0]         lo, up, tmp;
        int                 guard;

        resetN   = 1'b0;
        cfgWe    = 1'b0;
        cfgLower = '0;
        cfgUpper = '0;
        inValid  = 1'b0;
        inData   = '0;
        refLower = 8'h00;
        refUpper = 8'hFF;
        @(negedge clock);
        checkOutput("inReadyDuringReset", 128'(inReady), 128'(0));
        @(posedge clock);
        #1;
        resetN = 1'b1;
        @(negedge clock);
        checkOutput("resetInReady", 128'(inReady), 128'(1));
        checkOutput("resetLower", 128'(chkLower), 128'(8'h00));
        checkOutput("resetUpper", 128'(chkUpper), 128'(8'hFF));
        checkOutput("resetVector", 128'(chkVector), 128'(0));
        checkOutput("resetOutputs", 128'({chkStart, cfgErr, resValid, resErrMask, resErrCount, resFirstErr, resTimeout}), 128'(0));
        @(posedge clock);
        #1;

        // Stray completion while loading must not create a result
        strayReq++;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        checkOutput("strayDoneInLoad", 128'(resValid), 128'(0));
        @(posedge clock);
        #1;

        writeBounds(8'h56, 8'hD5, 1'b1);
        foreach (frameData[i]) frameData[i] = 8'h55;
        frameData[8]  = 8'hD4;
        frameData[11] = 8'h57;
        sendFrame(1'b0, 1'b0);
        checkOutput("vectorSlot8", 128'(chkVector[71:64]), 128'(8'hD4));
        waitResults();

        foreach (frameData[i]) frameData[i] = 8'($urandom_range(8'h56, 8'hD5));
        sendFrame(1'b1, 1'b0);
        waitResults();

        // Rejected writes: inverted bounds in LOAD, then any write while WAITing
        writeBounds(8'hF0, 8'h10, 1'b1);
        writeBounds(8'h80, 8'h80, 1'b1);
        writeBounds(8'h56, 8'hD5, 1'b1);
        foreach (frameData[i]) frameData[i] = 8'($urandom);
        checkerMode = 1;
        readyMode   = 2;
        sendFrame(1'b0, 1'b0);
        writeBounds(8'h10, 8'h20, 1'b0);
        guard = 0;
        while (!resValid && guard < 50) begin
            @(posedge clock);
            #1;
            guard++;
        end
        @(negedge clock);
        checkOutput("reportReached", 128'(resValid), 128'(1));
        snapMask  = resErrMask;
        snapCount = resErrCount;
        snapFirst = resFirstErr;
        @(posedge clock);
        #1;
        strayReq++;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            checkOutput("holdValid", 128'(resValid), 128'(1));
            checkOutput("holdInReady", 128'(inReady), 128'(0));
            checkOutput("holdFields", 128'({resErrMask, resErrCount, resFirstErr}), 128'({snapMask, snapCount, snapFirst}));
            checkOutput("holdVector", 128'(chkVector), 128'(packFrame()));
            @(posedge clock);
            #1;
        end
        checkerMode = 0;
        readyMode   = 0;
        waitResults();
        @(negedge clock);
        checkOutput("inReadyAfterHandshake", 128'(inReady), 128'(1));
        @(posedge clock);
        #1;

        // Element and bound write together on the first slot both take effect
        foreach (frameData[i]) frameData[i] = 8'($urandom);
        cfgWe    = 1'b1;
        cfgLower = 8'h30;
        cfgUpper = 8'hB0;
        inValid  = 1'b1;
        inData   = frameData[0];
        @(posedge clock);
        #1;
        cfgWe    = 1'b0;
        refLower = 8'h30;
        refUpper = 8'hB0;
        applyStimulus(1'b0, 1, VEC_LEN);
        expQ.push_back(modelFrame(refLower, refUpper));
        checkOutput("concurrentLower", 128'(chkLower), 128'(8'h30));
        checkOutput("concurrentUpper", 128'(chkUpper), 128'(8'hB0));
        waitResults();

        // Reset part-way through a frame discards it
        foreach (frameData[i]) frameData[i] = 8'($urandom);
        applyStimulus(1'b0, 0, 5);
        resetN = 1'b0;
        @(posedge clock);
        #1;
        resetN   = 1'b1;
        refLower = 8'h00;
        refUpper = 8'hFF;
        @(negedge clock);
        checkOutput("midResetLower", 128'(chkLower), 128'(8'h00));
        checkOutput("midResetUpper", 128'(chkUpper), 128'(8'hFF));
        @(posedge clock);
        #1;
        foreach (frameData[i]) frameData[i] = 8'($urandom);
        sendFrame(1'b0, 1'b0);
        waitResults();

`ifdef RANGE_SEQ_TIMEOUT_EN
        checkerMode = 2;
        foreach (frameData[i]) frameData[i] = 8'($urandom);
        sendFrame(1'b0, 1'b1);
        guard = 1;
        while (guard < 200) begin
            @(negedge clock);
            if (resValid) break;
            guard++;
            @(posedge clock);
            #1;
        end
        checkOutput("timeoutWaitCycles", 128'(guard), 128'(64));
        @(posedge clock);
        #1;
        waitResults();
        checkerMode = 0;
`endif

        for (int f = 0; f < 15; f++) begin
            readyMode = 1;
            if ($urandom_range(0, 2) == 0) begin
                lo = 8'($urandom);
                up = 8'($urandom);
                if (lo > up) begin
                    tmp = lo;
                    lo  = up;
                    up  = tmp;
                end
                writeBounds(lo, up, 1'b1);
            end
            foreach (frameData[i]) begin
                case ($urandom_range(0, 4))
                    0:       frameData[i] = refLower;
                    1:       frameData[i] = refUpper;
                    2:       frameData[i] = refLower - 8'd1;
                    3:       frameData[i] = refUpper + 8'd1;
                    default: frameData[i] = 8'($urandom);
                endcase
            end
            sendFrame(1'b1, 1'b0);
            waitResults();
        end
        readyMode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
